// File: rtl/root_real_pkg.sv
// Shared types and IEEE-754 single-precision helpers for the ROOT_REAL scheduler.
// Holds the FSM state encoding, canonical constants and operand classifiers.
// Pure declarations; no logic of its own.
package root_real_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [31:0] ONE  = 32'h3F80_0000;

  // All-ones exponent with a non-zero fraction.
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // All-ones exponent with a zero fraction, either sign.
  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // +0 or -0 only; denormals are not treated as zero here.
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/root_real_sched_if.sv
// Request/response bundle between the math-unit bus and the ROOT_REAL scheduler.
// master = requesters plus result consumer; slave = scheduler.
// Valid/ready on both request ports and on the response port.
interface root_real_sched_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_base;
  logic [31:0] req0_root;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_base;
  logic [31:0] req1_root;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;

  modport master (
    output req0_valid, req0_base, req0_root,
    input  req0_ready,
    output req1_valid, req1_base, req1_root,
    input  req1_ready,
    input  resp_valid, resp_data, resp_id,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_base, req0_root,
    output req0_ready,
    input  req1_valid, req1_base, req1_root,
    output req1_ready,
    output resp_valid, resp_data, resp_id,
    input  resp_ready
  );

endinterface

// File: rtl/ROOT_REAL.sv
// Combinational out = base^(1/root), IEEE-754 single, via log2 / divide / exp2.
// Pure combinational, long path: the scheduler treats it as a multicycle path.
// No handshake; the caller must hold inputs stable until it samples out.
module ROOT_REAL
  import root_real_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] root,
  output logic [31:0] out
);

  logic signed [32:0] log_b;     // log2(base), 23 fraction bits
  logic        [31:0] log_mag;
  logic        [7:0]  re;
  logic        [31:0] root_fix;  // |root|, 16 fraction bits
  logic        [47:0] quo_mag;   // |log2(base)/root|, 23 fraction bits
  logic               quo_neg;
  logic        [7:0]  qk;
  logic        [22:0] frac;
  logic signed [9:0]  ex;
  logic        [22:0] mant;
  logic        [31:0] calc;

  // Piecewise-linear log2, fixed-point divide, piecewise-linear exp2, then specials.
  always_comb begin
    // Biased exponent:fraction minus bias is the linear log2 approximation.
    log_b   = $signed({2'b00, base[30:0]}) - 33'sh0_3F80_0000;
    log_mag = log_b[32] ? (32'd0 - log_b[31:0]) : log_b[31:0];

    re = root[30:23];
    if (re > 8'd142)       root_fix = 32'hFFFF_FFFF;
    else if (re >= 8'd134) root_fix = {8'd0, 1'b1, root[22:0]} << (re - 8'd134);
    else                   root_fix = {8'd0, 1'b1, root[22:0]} >> (8'd134 - re);

    quo_mag = (root_fix == 32'd0) ? 48'hFFFF_FFFF_FFFF
                                  : ({log_mag, 16'd0} / {16'd0, root_fix});
    quo_neg = log_b[32] ^ root[31];
    qk      = quo_mag[30:23];
    frac    = quo_mag[22:0];

    // 2^(k+f) ~ (1+f)*2^k; a negative exponent borrows one from the integer part.
    if (!quo_neg) begin
      ex   = $signed({2'b00, qk}) + 10'sd127;
      mant = frac;
    end else if (frac == 23'd0) begin
      ex   = 10'sd127 - $signed({2'b00, qk});
      mant = 23'd0;
    end else begin
      ex   = 10'sd126 - $signed({2'b00, qk});
      mant = 23'(24'h80_0000 - {1'b0, frac});
    end

    if (|quo_mag[47:31])    calc = quo_neg ? 32'd0 : PINF;
    else if (ex <= 10'sd0)  calc = 32'd0;
    else if (ex >= 10'sd255) calc = PINF;
    else                    calc = {1'b0, ex[7:0], mant};

    if (is_nan(base) || is_nan(root) || is_zero(root) || (base[31] && !is_zero(base)))
      out = QNAN;
    else if (is_zero(base)) out = root[31] ? PINF : 32'd0;
    else if (is_inf(base))  out = root[31] ? 32'd0 : PINF;
    else if (is_inf(root))  out = ONE;
    else                    out = calc;
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer names the requester preferred on a tie.
// Grant is combinational from req and the pointer (zero latency).
// The pointer moves to the loser only when advance confirms the grant was used.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  // Pick the valid requester; on a tie the pointer decides.
  always_comb begin
    gnt = 2'b00;
    if (ptr) begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end else begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end

  // After a used grant, prefer the other requester next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr <= 1'b0;
    else if (advance && |gnt)  ptr <= gnt[0];
  end

endmodule

// File: rtl/root_real_sched.sv
// Round-robin scheduler sharing one ROOT_REAL between two requesters; optional ROOT_SPECIAL_BYPASS_EN.
// Latency: accept in T -> resp_valid from T+SETTLE_CYCLES+1 (T+1 for bypassed specials).
// Single outstanding: requests are refused outside IDLE; response held until resp_ready.
module root_real_sched
  import root_real_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  root_real_sched_if.slave bus,
  output logic             busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || (2 ** CNT_W) <= SETTLE_CYCLES) begin : g_bad_cfg
    $error("root_real_sched: SETTLE_CYCLES must be 1..15 and below 2**CNT_W");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       op_base;
  logic [31:0]       op_root;
  logic              op_id;
  logic [31:0]       root_out;
  logic              resp_valid_q;
  logic [31:0]       resp_data_q;
  logic              resp_id_q;

  logic [1:0]        gnt;
  logic              idle;
  logic              take;
  logic              win_id;
  logic [31:0]       win_base;
  logic [31:0]       win_root;

  assign idle     = (state == IDLE);
  assign take     = idle && |gnt;
  assign win_id   = gnt[1];
  assign win_base = gnt[1] ? bus.req1_base : bus.req0_base;
  assign win_root = gnt[1] ? bus.req1_root : bus.req0_root;

  assign bus.req0_ready = idle && gnt[0];
  assign bus.req1_ready = idle && gnt[1];
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign busy           = !idle;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .advance (take),
    .gnt     (gnt)
  );

  ROOT_REAL u_root (
    .base (op_base),
    .root (op_root),
    .out  (root_out)
  );

`ifdef ROOT_SPECIAL_BYPASS_EN
  // NaN operands or a zero root always give the canonical NaN; no need to wait.
  logic win_special;
  assign win_special = is_nan(win_base) || is_nan(win_root) || is_zero(win_root);
`endif

  // Control FSM: accept, hold operands for the settle window, present the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_base      <= 32'd0;
      op_root      <= 32'd0;
      op_id        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_id_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            op_base <= win_base;
            op_root <= win_root;
            op_id   <= win_id;
`ifdef ROOT_SPECIAL_BYPASS_EN
            if (win_special) begin
              resp_data_q  <= QNAN;
              resp_id_q    <= win_id;
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end else
`endif
            begin
              cnt   <= CNT_W'(SETTLE_CYCLES - 1);
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            resp_data_q  <= root_out;
            resp_id_q    <= op_id;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_root_real_sched.sv
// Directed self-checking bench for root_real_sched with SETTLE_CYCLES=4.
// Inputs driven and outputs sampled around the falling edge.
// Covers reset, arbitration, latency, backpressure, aborts and special operands.
module tb_root_real_sched;

  localparam int SETTLE = 4;
`ifdef ROOT_SPECIAL_BYPASS_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = SETTLE + 1;
`endif

  logic clk;
  logic rst_n;
  logic busy;
  int   total;
  int   passed;

  root_real_sched_if bus ();

  root_real_sched #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request and return at the falling edge after its handshake.
  task automatic do_req(input bit who, input logic [31:0] b, input logic [31:0] r, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (who) begin
      bus.req1_valid = 1'b1; bus.req1_base = b; bus.req1_root = r;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_base = b; bus.req0_root = r;
    end
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if ((who ? bus.req1_ready : bus.req0_ready) === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    if (who) bus.req1_valid = 1'b0;
    else     bus.req0_valid = 1'b0;
  endtask

  // Count falling edges until resp_valid; lat is cycles since the handshake cycle, 0 on timeout.
  task automatic wait_resp(input int start, output int lat);
    lat = start;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (bus.resp_valid !== 1'b1) lat = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b expected 0", bus.resp_valid); else passed++;
    total++; if (bus.resp_data !== 32'd0) $display("FAIL reset_resp_data got %h expected 00000000", bus.resp_data); else passed++;
    total++; if (bus.resp_id !== 1'b0) $display("FAIL reset_resp_id got %b expected 0", bus.resp_id); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_release_busy got %b expected 0", busy); else passed++;
  endtask

  task automatic test_alternate();
    int ngnt, nresp, last_gnt;
    logic exp_id;
    ngnt = 0; nresp = 0; last_gnt = 0;
    bus.resp_ready = 1'b1;
    bus.req0_base = 32'h447A_0000; bus.req0_root = 32'h40A0_0000;
    bus.req1_base = 32'h4100_0000; bus.req1_root = 32'h4040_0000;
    for (int cyc = 0; cyc < 80 && nresp < 4; cyc++) begin
      @(negedge clk);
      bus.req0_valid = (ngnt < 4);
      bus.req1_valid = (ngnt < 4);
      #1;
      if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
        total++;
        if ({bus.req1_ready, bus.req0_ready} !== (ngnt[0] ? 2'b10 : 2'b01))
          $display("FAIL alt_grant%0d got %b expected %b", ngnt, {bus.req1_ready, bus.req0_ready}, (ngnt[0] ? 2'b10 : 2'b01));
        else passed++;
        if (ngnt > 0) begin
          total++;
          if (cyc - last_gnt != SETTLE + 2) $display("FAIL alt_interval%0d got %0d expected %0d", ngnt, cyc - last_gnt, SETTLE + 2);
          else passed++;
        end
        last_gnt = cyc;
        ngnt++;
      end
      if (bus.resp_valid === 1'b1) begin
        exp_id = nresp[0];
        total++;
        if (bus.resp_id !== exp_id) $display("FAIL alt_resp_id%0d got %b expected %b", nresp, bus.resp_id, exp_id);
        else passed++;
        total++;
        if (exp_id ? (bus.resp_data !== 32'h4000_0000)
                   : ($isunknown(bus.resp_data) || bus.resp_data < 32'h407E_0000 || bus.resp_data > 32'h407F_0000))
          $display("FAIL alt_resp_data%0d got %h expected %s", nresp, bus.resp_data, exp_id ? "40000000" : "407E0000..407F0000");
        else passed++;
        nresp++;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    total++; if (nresp != 4) $display("FAIL alt_resp_count got %0d expected 4", nresp); else passed++;
  endtask

  task automatic test_single();
    bit ok;
    int lat;
    bus.resp_ready = 1'b1;
    do_req(1'b0, 32'h447A_0000, 32'h40A0_0000, ok);
    total++; if (ok !== 1'b1) $display("FAIL single_accept got %b expected 1", ok); else passed++;
    wait_resp(1, lat);
    total++; if (lat != SETTLE + 1) $display("FAIL single_latency got %0d expected %0d", lat, SETTLE + 1); else passed++;
    total++; if (bus.resp_id !== 1'b0) $display("FAIL single_id got %b expected 0", bus.resp_id); else passed++;
    total++;
    if ($isunknown(bus.resp_data) || bus.resp_data < 32'h407E_0000 || bus.resp_data > 32'h407F_0000)
      $display("FAIL single_data got %h expected 407E0000..407F0000", bus.resp_data);
    else passed++;
    @(negedge clk);
    total++; if ({bus.resp_valid, busy} !== 2'b00) $display("FAIL single_done got %b expected 00", {bus.resp_valid, busy}); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    bus.resp_ready = 1'b0;
    do_req(1'b1, 32'h4100_0000, 32'h4040_0000, ok);
    wait_resp(1, lat);
    total++; if (lat != SETTLE + 1) $display("FAIL bp_latency got %0d expected %0d", lat, SETTLE + 1); else passed++;
    bus.req0_base = 32'h447A_0000; bus.req0_root = 32'h40A0_0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.req0_valid = 1'b1;
      #1;
      total++;
      if ({bus.resp_valid, bus.resp_data, bus.resp_id, bus.req0_ready, bus.req1_ready} !== {1'b1, 32'h4000_0000, 1'b1, 2'b00})
        $display("FAIL bp_hold%0d got v=%b d=%h id=%b rdy=%b expected v=1 d=40000000 id=1 rdy=00",
                 i, bus.resp_valid, bus.resp_data, bus.resp_id, {bus.req1_ready, bus.req0_ready});
      else passed++;
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({bus.resp_valid, busy, bus.req0_ready} !== 3'b001)
      $display("FAIL bp_release got %b expected 001", {bus.resp_valid, busy, bus.req0_ready});
    else passed++;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL bp_dropped_valid_busy got %b expected 0", busy); else passed++;
  endtask

  task automatic test_pulse_busy();
    bit ok;
    int lat;
    int extra;
    bus.resp_ready = 1'b1;
    do_req(1'b0, 32'h4100_0000, 32'h4040_0000, ok);
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_base = 32'h447A_0000; bus.req1_root = 32'h40A0_0000;
    #1;
    total++; if (bus.req1_ready !== 1'b0) $display("FAIL pulse_ready got %b expected 0", bus.req1_ready); else passed++;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    wait_resp(3, lat);
    total++;
    if ({lat, bus.resp_id, bus.resp_data} !== {SETTLE + 1, 1'b0, 32'h4000_0000})
      $display("FAIL pulse_resp got lat=%0d id=%b d=%h expected lat=%0d id=0 d=40000000", lat, bus.resp_id, bus.resp_data, SETTLE + 1);
    else passed++;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) extra++;
    end
    total++; if (extra != 0) $display("FAIL pulse_no_extra got %0d expected 0", extra); else passed++;
  endtask

  task automatic test_special();
    bit ok;
    int lat;
    bus.resp_ready = 1'b1;
    do_req(1'b0, 32'h7FFF_FFFF, 32'hBECC_CCCD, ok);
    wait_resp(1, lat);
    total++; if (lat != SPEC_LAT) $display("FAIL special_nan_latency got %0d expected %0d", lat, SPEC_LAT); else passed++;
    total++; if (bus.resp_data !== 32'h7FC0_0000) $display("FAIL special_nan_data got %h expected 7FC00000", bus.resp_data); else passed++;
    @(negedge clk);
    do_req(1'b1, 32'h4100_0000, 32'h0000_0000, ok);
    wait_resp(1, lat);
    total++; if (lat != SPEC_LAT) $display("FAIL special_zero_latency got %0d expected %0d", lat, SPEC_LAT); else passed++;
    total++;
    if ({bus.resp_data, bus.resp_id} !== {32'h7FC0_0000, 1'b1})
      $display("FAIL special_zero_data got %h/%b expected 7FC00000/1", bus.resp_data, bus.resp_id);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    bus.resp_ready = 1'b1;
    do_req(1'b0, 32'h447A_0000, 32'h40A0_0000, ok);
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL abort_busy_before got %b expected 1", busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.resp_valid, busy} !== 2'b00) $display("FAIL abort_in_reset got %b expected 00", {bus.resp_valid, busy}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    total++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
      $display("FAIL abort_rr_ptr got %b expected 01", {bus.req1_ready, bus.req0_ready});
    else passed++;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) $display("FAIL abort_no_resp got %0d expected 0", seen); else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_base = 32'd0; bus.req0_root = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_base = 32'd0; bus.req1_root = 32'd0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_alternate();
    test_single();
    test_backpressure();
    test_pulse_busy();
    test_special();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
